// File: rtl/operand_mac_seq_if.sv
// Operand/result handshake bundle for operand_mac_seq.
// The master side supplies operands and accepts results; the slave is the multiply stage.
interface operand_mac_seq_if #(
  parameter int A_W = 7,
  parameter int Y_W = 6
);
  localparam int P_W = A_W + 1 + Y_W;

  logic           in_valid;
  logic           in_ready;
  logic [A_W-1:0] a;
  logic [A_W-1:0] b;
  logic [Y_W-1:0] y;
  logic           out_valid;
  logic           out_ready;
  logic [P_W-1:0] p;
  logic           p_par;
  logic [A_W-1:0] a_q;
  logic [A_W-1:0] b_q;
  logic [Y_W-1:0] y_q;

  modport master (
    output in_valid, a, b, y, out_ready,
    input  in_ready, out_valid, p, p_par, a_q, b_q, y_q
  );

  modport slave (
    input  in_valid, a, b, y, out_ready,
    output in_ready, out_valid, p, p_par, a_q, b_q, y_q
  );
endinterface

// File: rtl/operand_mac_seq.sv
// Sequential multiply stage: p = (a+b)*y by shift-add, one multiplier bit per cycle,
// with fixed Y_W-cycle latency and a registered valid/ready handshake on both sides.
module operand_mac_seq #(
  parameter int A_W = 7,
  parameter int Y_W = 6
) (
  input logic              clk,
  input logic              rst,
  operand_mac_seq_if.slave bus
);
  localparam int P_W   = A_W + 1 + Y_W;
  localparam int CNT_W = (Y_W > 1) ? $clog2(Y_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(Y_W - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state_q, state_d;

  logic [A_W:0]     sum_r;
  logic [Y_W-1:0]   mplr;
  logic [P_W-1:0]   acc;
  logic [CNT_W-1:0] cnt;
  logic [A_W-1:0]   a_r, b_r;
  logic [Y_W-1:0]   y_r;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_d = CALC;
      end
      CALC: begin
        if (cnt == CNT_LAST) state_d = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // No early exit on mplr==0: latency stays fixed at Y_W CALC cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_r <= '0;
      mplr  <= '0;
      acc   <= '0;
      cnt   <= '0;
      a_r   <= '0;
      b_r   <= '0;
      y_r   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_r   <= bus.a;
            b_r   <= bus.b;
            y_r   <= bus.y;
            sum_r <= {1'b0, bus.a} + {1'b0, bus.b};
            mplr  <= bus.y;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        CALC: begin
          if (mplr[0]) acc <= acc + (P_W'(sum_r) << cnt);
          mplr <= mplr >> 1;
          cnt  <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.p     = acc;
  assign bus.p_par = ^acc;
  assign bus.a_q   = a_r;
  assign bus.b_q   = b_r;
  assign bus.y_q   = y_r;
endmodule

// File: tb/tb_operand_mac_seq.sv
// Directed bench for operand_mac_seq: latency, exact products, parity, backpressure,
// asynchronous reset mid-calculation and back-to-back throughput.
module tb_operand_mac_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;

  operand_mac_seq_if #(.A_W(7), .Y_W(6)) bus ();

  operand_mac_seq #(.A_W(7), .Y_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand set for a single accepting edge (caller ensures IDLE).
  task automatic accept(input logic [6:0] a, input logic [6:0] b, input logic [5:0] y);
    bus.a = a; bus.b = b; bus.y = y; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid; bounded.
  task automatic wait_out(output int n);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  int        lat;
  int        t_prev;
  logic [6:0] ra, rb;
  logic [5:0] ry;
  logic [13:0] ep;

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.y = '0;

    // Reset state while rst is held
    #3;
    check("rst_in_ready",  32'(bus.in_ready),  1);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_p",         32'(bus.p),         0);
    check("rst_p_par",     32'(bus.p_par),     0);
    check("rst_a_q",       32'(bus.a_q),       0);
    check("rst_y_q",       32'(bus.y_q),       0);
    tick();
    rst = 1'b0;

    // Basic: (5+3)*7 = 56
    bus.out_ready = 1'b1;
    accept(7'd5, 7'd3, 6'd7);
    check("basic_busy", 32'(bus.in_ready), 0);
    wait_out(lat);
    check("basic_latency", 32'(lat), 6);
    check("basic_p",     32'(bus.p),     56);
    check("basic_p_par", 32'(bus.p_par), 1);
    check("basic_a_q",   32'(bus.a_q),   5);
    check("basic_b_q",   32'(bus.b_q),   3);
    check("basic_y_q",   32'(bus.y_q),   7);
    check("basic_ready_in_done", 32'(bus.in_ready), 0);
    tick();
    check("basic_ready_back", 32'(bus.in_ready),  1);
    check("basic_valid_drop", 32'(bus.out_valid), 0);

    // Max operands: 254*63 = 16002
    accept(7'd127, 7'd127, 6'd63);
    wait_out(lat);
    check("max_latency", 32'(lat), 6);
    check("max_p",     32'(bus.p),     16002);
    check("max_p_par", 32'(bus.p_par), 1);
    tick();

    // Zero multiplier
    accept(7'd100, 7'd27, 6'd0);
    wait_out(lat);
    check("zero_latency", 32'(lat), 6);
    check("zero_p",     32'(bus.p),     0);
    check("zero_p_par", 32'(bus.p_par), 0);
    tick();

    // Backpressure with an ignored in_valid pulse
    bus.out_ready = 1'b0;
    accept(7'd1, 7'd0, 6'd1);
    wait_out(lat);
    check("bp_latency", 32'(lat), 6);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        bus.a = 7'd9; bus.b = 7'd0; bus.y = 6'd1; bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
      check("bp_out_valid", 32'(bus.out_valid), 1);
      check("bp_p",         32'(bus.p),         1);
      check("bp_p_par",     32'(bus.p_par),     1);
      check("bp_a_q",       32'(bus.a_q),       1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("bp_idle", 32'(bus.in_ready), 1);
    accept(7'd4, 7'd4, 6'd2);
    wait_out(lat);
    check("bp_next_p",   32'(bus.p),   16);
    check("bp_next_a_q", 32'(bus.a_q), 4);
    tick();

    // Asynchronous reset mid-calculation
    accept(7'd10, 7'd10, 6'd3);
    tick(); tick(); tick();
    #2 rst = 1'b1;
    #1;
    check("mid_rst_in_ready",  32'(bus.in_ready),  1);
    check("mid_rst_out_valid", 32'(bus.out_valid), 0);
    check("mid_rst_p",         32'(bus.p),         0);
    tick();
    rst = 1'b0;
    accept(7'd2, 7'd2, 6'd3);
    wait_out(lat);
    check("post_rst_latency", 32'(lat), 6);
    check("post_rst_p",     32'(bus.p),     12);
    check("post_rst_p_par", 32'(bus.p_par), 0);
    tick();

    // Back-to-back: in_valid held high, out_ready high
    t_prev = 0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ra = 7'($urandom_range(0, 127));
      rb = 7'($urandom_range(0, 127));
      ry = 6'($urandom_range(0, 63));
      ep = (14'(ra) + 14'(rb)) * 14'(ry);
      bus.a = ra; bus.b = rb; bus.y = ry;
      check("b2b_ready", 32'(bus.in_ready), 1);
      tick();
      bus.a = ~ra; bus.b = ~rb; bus.y = ~ry;
      wait_out(lat);
      check("b2b_p",     32'(bus.p),     32'(ep));
      check("b2b_p_par", 32'(bus.p_par), 32'(^ep));
      check("b2b_a_q",   32'(bus.a_q),   32'(ra));
      if (i > 0) check("b2b_interval", 32'($time - t_prev), 80);
      t_prev = int'($time);
      tick();
    end
    bus.in_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
